branch_compare: RTL and testbench

- Branch comparator for the RISC-V pipeline.
- Compares the two register operands rs1 and rs2 and reports equality and less-than, signed or unsigned.
- The control unit combines these flags to resolve BEQ/BNE/BLT/BGE/BLTU/BGEU.
- Primary flags are combinational, for same-cycle branch resolution. Registered copies are also provided for the downstream pipeline stage.

---
 rtl/branch_compare.sv | 62 ++++++
 tb/tb_branch_compare.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/branch_compare.sv
// Branch comparator: equality and signed/unsigned less-than between rs1 and rs2,
// available combinationally for same-cycle branch resolution and registered for the next stage.
module branch_compare #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic             i_br_un,
  output logic             o_br_equal,
  output logic             o_br_less,
  output logic             o_br_equal_r,
  output logic             o_br_less_r
);

  logic [WIDTH-1:0] bit_same;
  logic [WIDTH:0]   borrow;
  logic             unsigned_less;
  logic             sign_differs;
  logic             less_p0;
  logic             equal_p0;

  // Equality: per-bit XNOR, then AND-reduction across the word.
  assign bit_same = ~(i_rs1_data ^ i_rs2_data);
  assign equal_p0 = &bit_same;

  // Magnitude chain: ripple borrow of A - B from the LSB upward.
  assign borrow[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_borrow
    assign borrow[i+1] = (~i_rs1_data[i] & i_rs2_data[i]) | (bit_same[i] & borrow[i]);
  end
  assign unsigned_less = borrow[WIDTH];

  // Sign fixup: with differing sign bits in signed mode, the negative operand is smaller.
  assign sign_differs = i_rs1_data[WIDTH-1] ^ i_rs2_data[WIDTH-1];

  always_comb begin
    less_p0 = unsigned_less;
    if (i_br_un && sign_differs) begin
      less_p0 = i_rs1_data[WIDTH-1];
    end
    if (equal_p0) begin
      less_p0 = 1'b0;
    end
  end

  assign o_br_equal = equal_p0;
  assign o_br_less  = less_p0;

  // Stage p0 -> p1: registered copies for the downstream stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_br_equal_r <= 1'b0;
      o_br_less_r  <= 1'b0;
    end else begin
      o_br_equal_r <= equal_p0;
      o_br_less_r  <= less_p0;
    end
  end

endmodule

// File: tb/tb_branch_compare.sv
// Bench for branch_compare: table vectors, random vectors against a relational model,
// and hand-written reset / mode-toggle sequences.
module tb_branch_compare;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a, b;
  logic         br_un;
  logic         eq, lt, eq_r, lt_r;

  always #5 clk = ~clk;

  branch_compare #(.WIDTH(W)) dut (
    .i_clk(clk), .i_reset(reset), .i_rs1_data(a), .i_rs2_data(b), .i_br_un(br_un),
    .o_br_equal(eq), .o_br_less(lt), .o_br_equal_r(eq_r), .o_br_less_r(lt_r)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         un;
    logic         eq;
    logic         lt;
  } vec_t;

  typedef struct {
    logic eq;
    logic lt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (a=%h b=%h un=%b)", name, act, exp, a, b, br_un);
    end
  endtask

  // Drive one operand pair, check the combinational flags, then the registered copy a cycle later.
  task automatic apply(input logic [W-1:0] va, input logic [W-1:0] vb, input logic un,
                       input logic xeq, input logic xlt);
    exp_t e;
    a = va; b = vb; br_un = un;
    #1;
    check("comb_equal", eq, xeq);
    check("comb_less", lt, xlt);
    e.eq = xeq; e.lt = xlt;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check("reg_equal", eq_r, e.eq);
      check("reg_less", lt_r, e.lt);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb, input logic un,
                              input logic xeq, input logic xlt);
    vec_t v;
    v.a = va; v.b = vb; v.un = un; v.eq = xeq; v.lt = xlt;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back(mk(32'hFFFFFB3C, 32'd103990, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'hFFFFFB3C, 32'd103990, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(32'd300029,   32'd300029, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(32'd29,       32'd29,     1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(32'd45029,    32'd300029, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(32'd45029,    32'd300029, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(32'hFFFF5013, 32'hFFFB6C03, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'hFFFF5013, 32'hFFFB6C03, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(32'h00000002, 32'h00000001, 1'b1, 1'b0, 1'b0));

    // Reset held for two cycles with equal operands: registered flags stay 0, comb flag is free.
    reset = 1'b1; a = '0; b = '0; br_un = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_equal_r", eq_r, 1'b0);
    check("reset_less_r", lt_r, 1'b0);
    check("reset_comb_equal", eq, 1'b1);
    a = 32'd1; b = 32'd2; #1;
    check("reset_comb_less", lt, 1'b1);
    @(posedge clk); #1;
    check("reset_hold_less_r", lt_r, 1'b0);
    reset = 1'b0;

    apply(32'd5, 32'd9, 1'b1, 1'b0, 1'b1);

    foreach (vecs[i]) apply(vecs[i].a, vecs[i].b, vecs[i].un, vecs[i].eq, vecs[i].lt);

    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb;
      logic         run, xeq, xlt;
      ra  = $urandom;
      rb  = (i % 8 == 0) ? ra : ((i % 5 == 0) ? (ra ^ (32'h1 << (i % 32))) : $urandom);
      run = $urandom_range(0, 1);
      xeq = (ra == rb);
      xlt = run ? ($signed(ra) < $signed(rb)) : (ra < rb);
      apply(ra, rb, run, xeq, xlt);
    end

    // Mode toggle with constant operands updates less immediately, equal untouched.
    a = 32'h80000000; b = 32'h7FFFFFFF; br_un = 1'b1; #1;
    check("toggle_less_signed", lt, 1'b1);
    check("toggle_equal_signed", eq, 1'b0);
    br_un = 1'b0; #1;
    check("toggle_less_unsigned", lt, 1'b0);
    check("toggle_equal_unsigned", eq, 1'b0);

    // Reset asserted mid-stream clears both registered flags on the next edge.
    a = 32'd7; b = 32'd7; br_un = 1'b0;
    @(posedge clk); #1;
    check("midstream_equal_r_set", eq_r, 1'b1);
    a = 32'd3; b = 32'd7; br_un = 1'b1;
    @(posedge clk); #1;
    check("midstream_less_r_set", lt_r, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midstream_equal_r_clr", eq_r, 1'b0);
    check("midstream_less_r_clr", lt_r, 1'b0);
    check("midstream_comb_less", lt, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("after_reset_less_r", lt_r, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
